// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master)
// and the instruction memory (slave).
interface instr_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, fetches over a req/ack bus, decodes
// IR fields and applies next-PC selection on FSM commit strobes.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       instrReg,
  input  logic                       pc_update,
  input  logic                       jump,
  input  logic                       jr,
  input  logic                       beq,
  input  logic                       bne,
  input  logic                       zero,
  input  logic [31:0]                rs_data,
  instr_fetch_unit_if.master         imem,
  output logic [5:0]                 opcode,
  output logic [5:0]                 funct,
  output logic [4:0]                 rs,
  output logic [4:0]                 rt,
  output logic [4:0]                 rd,
  output logic [15:0]                imm,
  output logic [25:0]                target,
  output logic [31:0]                pc,
  output logic [31:0]                link_addr,
  output logic                       ir_valid,
  output logic                       busy,
  output logic [1:0]                 fault
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t           state_reg;
  logic [31:0]      pc_reg;
  logic [31:0]      ir_reg;
  logic             ir_valid_reg;
  logic             req_reg;
  logic             busy_reg;
  logic [1:0]       fault_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [31:0]      pc_next;
  logic [31:0]      branch_off;
  logic             branch_taken;
  logic             jr_misaligned;

  // Next-PC selection: jr > jump > taken branch > hold.
  always_comb begin
    branch_off    = {{14{ir_reg[15]}}, ir_reg[15:0], 2'b00};
    branch_taken  = (beq && zero) || (bne && !zero);
    pc_next       = pc_reg;
    jr_misaligned = 1'b0;
    if (jr) begin
      pc_next       = rs_data & ~32'h3;
      jr_misaligned = |rs_data[1:0];
    end else if (jump) begin
      pc_next = {pc_reg[31:28], ir_reg[25:0], 2'b00};
    end else if (branch_taken) begin
      pc_next = pc_reg + branch_off;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      ir_reg       <= 32'h0;
      ir_valid_reg <= 1'b0;
      req_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      fault_reg    <= 2'b00;
      cnt_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pc_update) begin
            pc_reg <= pc_next;
            if (jr_misaligned) begin
              fault_reg[1] <= 1'b1;
            end
          end
          if (instrReg) begin
            ir_valid_reg <= 1'b0;
            busy_reg     <= 1'b1;
            cnt_reg      <= '0;
            // A same-cycle commit needs one cycle for the new PC to settle
            if (pc_update) begin
              state_reg <= PEND;
            end else begin
              state_reg <= REQ;
              req_reg   <= 1'b1;
            end
          end
        end
        PEND: begin
          state_reg <= REQ;
          req_reg   <= 1'b1;
        end
        REQ: begin
          if (imem.ack) begin
            ir_reg       <= imem.rdata;
            ir_valid_reg <= 1'b1;
            pc_reg       <= pc_reg + 32'd4;
            req_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            cnt_reg      <= '0;
            state_reg    <= IDLE;
          end else if (cnt_reg == LAST_CNT) begin
            req_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            fault_reg[0] <= 1'b1;
            cnt_reg      <= '0;
            state_reg    <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          req_reg   <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign imem.req  = req_reg;
  assign imem.addr = {pc_reg[31:2], 2'b00};

  assign opcode    = ir_reg[31:26];
  assign funct     = ir_reg[5:0];
  assign rs        = ir_reg[25:21];
  assign rt        = ir_reg[20:16];
  assign rd        = ir_reg[15:11];
  assign imm       = ir_reg[15:0];
  assign target    = ir_reg[25:0];
  assign pc        = pc_reg;
  assign link_addr = pc_reg;
  assign ir_valid  = ir_valid_reg;
  assign busy      = busy_reg;
  assign fault     = fault_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// fetch/commit traffic compared against a behavioural PC/IR model.
module tb_instr_fetch_unit;
  localparam int          TO     = 16;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        instrReg = 1'b0;
  logic        pc_update = 1'b0;
  logic        jump = 1'b0;
  logic        jr = 1'b0;
  logic        beq = 1'b0;
  logic        bne = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] rs_data = 32'h0;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] pc, link_addr;
  logic        ir_valid, busy;
  logic [1:0]  fault;

  instr_fetch_unit_if imem_bus ();

  instr_fetch_unit #(.RESET_PC(RST_PC), .ACK_TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .instrReg  (instrReg),
    .pc_update (pc_update),
    .jump      (jump),
    .jr        (jr),
    .beq       (beq),
    .bne       (bne),
    .zero      (zero),
    .rs_data   (rs_data),
    .imem      (imem_bus),
    .opcode    (opcode),
    .funct     (funct),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .imm       (imm),
    .target    (target),
    .pc        (pc),
    .link_addr (link_addr),
    .ir_valid  (ir_valid),
    .busy      (busy),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference state
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  bit          m_valid;
  logic [1:0]  m_fault;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc    = RST_PC;
    m_ir    = 32'h0;
    m_valid = 1'b0;
    m_fault = 2'b00;
  endtask

  function automatic logic [31:0] ref_next_pc(bit j_r, bit jmp, bit b_eq, bit b_ne, bit z,
                                              logic [31:0] rsv);
    logic signed [15:0] ofs;
    if (j_r) return rsv - (rsv % 4);
    if (jmp) return (m_pc & 32'hF000_0000) + ((m_ir & 32'h03FF_FFFF) * 4);
    if ((b_eq && z) || (b_ne && !z)) begin
      ofs = m_ir[15:0];
      return m_pc + 32'(int'(ofs) * 4);
    end
    return m_pc;
  endfunction

  task automatic drive_sel(bit j_r, bit jmp, bit b_eq, bit b_ne, bit z, logic [31:0] rsv);
    jr = j_r; jump = jmp; beq = b_eq; bne = b_ne; zero = z; rs_data = rsv;
  endtask

  task automatic do_update(input string tag, input bit j_r, input bit jmp, input bit b_eq,
                           input bit b_ne, input bit z, input logic [31:0] rsv);
    m_pc = ref_next_pc(j_r, jmp, b_eq, b_ne, z, rsv);
    if (j_r && (rsv % 4) != 0) m_fault[1] = 1'b1;
    drive_sel(j_r, jmp, b_eq, b_ne, z, rsv);
    pc_update = 1'b1;
    step();
    pc_update = 1'b0;
    drive_sel(0, 0, 0, 0, 0, 32'h0);
    tests_run++;
    if (pc !== m_pc || link_addr !== m_pc) begin
      tests_failed++;
      $display("FAIL %s upd_pc: pc=%h link=%h expected %h", tag, pc, link_addr, m_pc);
    end
    tests_run++;
    if (fault !== m_fault || busy !== 1'b0 || imem_bus.req !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s upd_state: fault=%b busy=%b req=%b expected fault=%b busy=0 req=0",
               tag, fault, busy, imem_bus.req, m_fault);
    end
  endtask

  // ack_cycle: req cycle (1-based) on which ack is returned; 0 = never
  task automatic do_fetch(input string tag, input int ack_cycle, input logic [31:0] word,
                          input bit upd, input bit j_r, input bit jmp, input bit b_eq,
                          input bit b_ne, input bit z, input logic [31:0] rsv, input bit glitch);
    logic [31:0] exp_addr;
    bit acked;
    if (upd) begin
      m_pc = ref_next_pc(j_r, jmp, b_eq, b_ne, z, rsv);
      if (j_r && (rsv % 4) != 0) m_fault[1] = 1'b1;
      drive_sel(j_r, jmp, b_eq, b_ne, z, rsv);
      pc_update = 1'b1;
    end
    exp_addr = m_pc;
    instrReg = 1'b1;
    step();
    instrReg = 1'b0;
    pc_update = 1'b0;
    drive_sel(0, 0, 0, 0, 0, 32'h0);
    if (upd) begin
      tests_run++;
      if (busy !== 1'b1 || imem_bus.req !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s pend: busy=%b req=%b expected busy=1 req=0", tag, busy, imem_bus.req);
      end
      step();
    end
    acked = 1'b0;
    for (int i = 1; i <= TO; i++) begin
      tests_run++;
      if (imem_bus.req !== 1'b1 || imem_bus.addr !== exp_addr || busy !== 1'b1 ||
          ir_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s req_hold cycle %0d: req=%b addr=%h busy=%b ir_valid=%b expected 1 %h 1 0",
                 tag, i, imem_bus.req, imem_bus.addr, busy, ir_valid, exp_addr);
      end
      if (glitch && i == 1) begin
        instrReg = 1'b1; pc_update = 1'b1; jr = 1'b1; rs_data = $urandom;
      end
      if (i == ack_cycle) begin
        imem_bus.ack = 1'b1;
        imem_bus.rdata = word;
        acked = 1'b1;
      end
      step();
      instrReg = 1'b0; pc_update = 1'b0; jr = 1'b0; rs_data = 32'h0;
      imem_bus.ack = 1'b0;
      imem_bus.rdata = $urandom;
      if (acked) break;
    end
    if (acked) begin
      m_ir = word; m_valid = 1'b1; m_pc = m_pc + 32'd4;
    end else begin
      m_fault[0] = 1'b1; m_valid = 1'b0;
    end
    tests_run++;
    if (imem_bus.req !== 1'b0 || busy !== 1'b0 || pc !== m_pc || fault !== m_fault ||
        ir_valid !== m_valid) begin
      tests_failed++;
      $display("FAIL %s done: req=%b busy=%b pc=%h fault=%b ir_valid=%b expected 0 0 %h %b %b",
               tag, imem_bus.req, busy, pc, fault, ir_valid, m_pc, m_fault, m_valid);
    end
    tests_run++;
    if (opcode !== m_ir[31:26] || funct !== m_ir[5:0] || rs !== m_ir[25:21] ||
        rt !== m_ir[20:16] || rd !== m_ir[15:11] || imm !== m_ir[15:0] ||
        target !== m_ir[25:0]) begin
      tests_failed++;
      $display("FAIL %s fields: op=%h fn=%h rs=%h rt=%h rd=%h imm=%h tgt=%h expected ir=%h",
               tag, opcode, funct, rs, rt, rd, imm, target, m_ir);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    step();
    step();
    reset_n = 1'b1;
    step();
    tests_run++;
    if (pc !== RST_PC || imem_bus.req !== 1'b0 || busy !== 1'b0 || fault !== 2'b00 ||
        ir_valid !== 1'b0 || opcode !== 6'h0 || target !== 26'h0) begin
      tests_failed++;
      $display("FAIL reset: pc=%h req=%b busy=%b fault=%b ir_valid=%b op=%h tgt=%h expected %h 0 0 00 0 0 0",
               pc, imem_bus.req, busy, fault, ir_valid, opcode, target, RST_PC);
    end
  endtask

  task automatic test_fetch();
    do_fetch("fetch", 3, 32'h0000_002A, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    tests_run++;
    if (funct !== 6'h2A || opcode !== 6'h00 || pc !== 32'h4 || ir_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL fetch_spec: funct=%h opcode=%h pc=%h ir_valid=%b expected 2a 00 00000004 1",
               funct, opcode, pc, ir_valid);
    end
  endtask

  task automatic test_branch();
    do_fetch("br_fetch", 2, 32'h1000_FFFF, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    tests_run++;
    if (pc !== 32'h8) begin
      tests_failed++;
      $display("FAIL br_setup: pc=%h expected 00000008", pc);
    end
    do_update("beq_taken", 0, 0, 1, 0, 1, 32'h0);
    tests_run++;
    if (pc !== 32'h4) begin
      tests_failed++;
      $display("FAIL beq_taken_spec: pc=%h expected 00000004", pc);
    end
    do_update("br_restore", 1, 0, 0, 0, 0, 32'h8);
    do_update("beq_not", 0, 0, 1, 0, 0, 32'h0);
    tests_run++;
    if (pc !== 32'h8) begin
      tests_failed++;
      $display("FAIL beq_not_spec: pc=%h expected 00000008", pc);
    end
    do_update("bne_taken", 0, 0, 0, 1, 0, 32'h0);
    tests_run++;
    if (pc !== 32'h4) begin
      tests_failed++;
      $display("FAIL bne_taken_spec: pc=%h expected 00000004", pc);
    end
  endtask

  task automatic test_jump();
    do_update("j_setup", 1, 0, 0, 0, 0, 32'h1000_0000);
    do_fetch("j_fetch", 1, 32'h0800_0100, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    tests_run++;
    if (link_addr !== 32'h1000_0004) begin
      tests_failed++;
      $display("FAIL link_addr: link=%h expected 10000004", link_addr);
    end
    do_update("jump", 0, 1, 0, 0, 0, 32'h0);
    tests_run++;
    if (pc !== 32'h1000_0400) begin
      tests_failed++;
      $display("FAIL jump_spec: pc=%h expected 10000400", pc);
    end
  endtask

  task automatic test_jr();
    do_update("jr_mis", 1, 0, 0, 0, 0, 32'h0000_0043);
    tests_run++;
    if (pc !== 32'h40 || fault !== 2'b10) begin
      tests_failed++;
      $display("FAIL jr_spec: pc=%h fault=%b expected 00000040 10", pc, fault);
    end
    do_update("jr_prio", 1, 1, 1, 0, 1, 32'h0000_0080);
    tests_run++;
    if (pc !== 32'h80) begin
      tests_failed++;
      $display("FAIL jr_prio_spec: pc=%h expected 00000080", pc);
    end
  endtask

  task automatic test_pend();
    do_fetch("pend", 1, 32'h2402_0005, 1, 0, 1, 0, 0, 0, 32'h0, 0);
    tests_run++;
    if (pc !== 32'h404) begin
      tests_failed++;
      $display("FAIL pend_spec: pc=%h expected 00000404", pc);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] pc_before;
    pc_before = pc;
    do_fetch("timeout", 0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 1);
    tests_run++;
    if (fault !== 2'b11 || pc !== pc_before) begin
      tests_failed++;
      $display("FAIL timeout_spec: fault=%b pc=%h expected 11 %h", fault, pc, pc_before);
    end
  endtask

  task automatic test_wrap();
    do_update("wrap_setup", 1, 0, 0, 0, 0, 32'hFFFF_FFFC);
    do_fetch("wrap", 2, 32'h0000_0020, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    tests_run++;
    if (pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_spec: pc=%h expected 00000000", pc);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int kind;
      int ackc;
      logic [31:0] rsv;
      kind = $urandom_range(0, 2);
      ackc = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO - 1);
      rsv  = $urandom;
      if ($urandom_range(0, 7) != 0) rsv[1:0] = 2'b00;
      if (kind == 0) begin
        do_update("rnd_upd", ($urandom_range(0, 4) == 0), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), rsv);
      end else begin
        do_fetch("rnd_fetch", ackc, $urandom, (kind == 2), ($urandom_range(0, 4) == 0),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), rsv, 1'($urandom));
      end
    end
  endtask

  task automatic test_reset_mid_req();
    do_update("mid_setup", 1, 0, 0, 0, 0, 32'h0000_1230);
    instrReg = 1'b1;
    step();
    instrReg = 1'b0;
    step();
    tests_run++;
    if (imem_bus.req !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_req_active: req=%b expected 1", imem_bus.req);
    end
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if (imem_bus.req !== 1'b0 || pc !== RST_PC || busy !== 1'b0 || fault !== 2'b00 ||
        ir_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: req=%b pc=%h busy=%b fault=%b ir_valid=%b expected 0 %h 0 00 0",
               imem_bus.req, pc, busy, fault, ir_valid, RST_PC);
    end
    step();
    reset_n = 1'b1;
    step();
    do_fetch("post_reset", 2, 32'h8C01_0004, 0, 0, 0, 0, 0, 0, 32'h0, 0);
  endtask

  initial begin
    imem_bus.ack   = 1'b0;
    imem_bus.rdata = 32'h0;
    model_reset();
    test_reset();
    test_fetch();
    test_branch();
    test_jump();
    test_jr();
    test_pend();
    test_timeout();
    test_wrap();
    test_random();
    test_reset_mid_req();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
